handshake_const_seq: RTL and testbench

HANDSHAKE_CONST_SEQ -- requirements
Module: handshake_const_seq

---
 rtl/handshake_const_seq.sv | 103 ++++++++++
 tb/tb_handshake_const_seq.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/handshake_const_seq.sv
// Constant-token sequencer: each accepted control token releases the next
// entry of a parameter table through a one-entry registered output stage.
module handshake_const_seq #(
  parameter int unsigned                     DATA_WIDTH = 32,
  parameter int unsigned                     DEPTH      = 4,
  parameter logic [DEPTH*DATA_WIDTH-1:0]     TABLE      = '0,
  parameter bit                              WRAP       = 1'b1
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          ctrl_valid,
  output logic                                          ctrl_ready,
  input  logic                                          restart,
  output logic [DATA_WIDTH-1:0]                         outs,
  output logic                                          outs_valid,
  input  logic                                          outs_ready,
  output logic                                          outs_last,
  output logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0]  idx
);

  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] outs_q, outs_d;
  logic                  outs_valid_q, outs_valid_d;
  logic                  outs_last_q, outs_last_d;
  logic [IW-1:0]         idx_q, idx_d;

  logic [DATA_WIDTH-1:0] table_word;
  logic                  ctrl_ready_c;
  logic                  ctrl_fire;
  logic                  out_fire;

  // Output stage can take a new token when empty or draining this cycle;
  // depends only on registered state and outs_ready, never on ctrl_valid.
  always_comb begin
    ctrl_ready_c = !outs_valid_q || outs_ready;
    ctrl_fire    = ctrl_valid && ctrl_ready_c;
    out_fire     = outs_valid_q && outs_ready;
  end

  // Table lookup at the current index.
  always_comb begin
    table_word = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (idx_q == IW'(i)) begin
        table_word = TABLE[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Index sequencing: advance on fire, wrap or saturate at the end,
  // restart overrides the advance but not the token being emitted.
  always_comb begin
    idx_d = idx_q;
    if (ctrl_fire) begin
      if (idx_q == LAST_IDX) begin
        idx_d = WRAP ? '0 : LAST_IDX;
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end
    if (restart) begin
      idx_d = '0;
    end
  end

  // Output register: load on ctrl fire, empty on drain, otherwise hold.
  always_comb begin
    outs_d       = outs_q;
    outs_last_d  = outs_last_q;
    outs_valid_d = outs_valid_q;
    if (ctrl_fire) begin
      outs_d       = table_word;
      outs_last_d  = (idx_q == LAST_IDX);
      outs_valid_d = 1'b1;
    end else if (out_fire) begin
      outs_valid_d = 1'b0;
    end
  end

  // State registers; reset drops any held token.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outs_q       <= '0;
      outs_last_q  <= 1'b0;
      outs_valid_q <= 1'b0;
      idx_q        <= '0;
    end else begin
      outs_q       <= outs_d;
      outs_last_q  <= outs_last_d;
      outs_valid_q <= outs_valid_d;
      idx_q        <= idx_d;
    end
  end

  assign ctrl_ready = ctrl_ready_c;
  assign outs       = outs_q;
  assign outs_last  = outs_last_q;
  assign outs_valid = outs_valid_q;
  assign idx        = idx_q;

endmodule

// File: tb/tb_handshake_const_seq.sv
// Bench for handshake_const_seq: three configurations (wrap, saturate,
// single entry), a queue scoreboard plus a table of explicit vectors.
module tb_handshake_const_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // DUT0: DEPTH=3, WRAP=1
  logic cv0, rs0, or0, rdy0, ov0, ol0;
  logic [7:0] o0;
  logic [1:0] ix0;
  // DUT1: DEPTH=3, WRAP=0
  logic cv1, rs1, or1, rdy1, ov1, ol1;
  logic [7:0] o1;
  logic [1:0] ix1;
  // DUT2: DEPTH=1, TABLE=A5
  logic cv2, rs2, or2, rdy2, ov2, ol2;
  logic [7:0] o2;
  logic [0:0] ix2;

  handshake_const_seq #(.DATA_WIDTH(8), .DEPTH(3), .TABLE(24'h332211), .WRAP(1'b1)) u_wrap (
    .clk(clk), .rst(rst), .ctrl_valid(cv0), .ctrl_ready(rdy0), .restart(rs0),
    .outs(o0), .outs_valid(ov0), .outs_ready(or0), .outs_last(ol0), .idx(ix0));

  handshake_const_seq #(.DATA_WIDTH(8), .DEPTH(3), .TABLE(24'h332211), .WRAP(1'b0)) u_sat (
    .clk(clk), .rst(rst), .ctrl_valid(cv1), .ctrl_ready(rdy1), .restart(rs1),
    .outs(o1), .outs_valid(ov1), .outs_ready(or1), .outs_last(ol1), .idx(ix1));

  handshake_const_seq #(.DATA_WIDTH(8), .DEPTH(1), .TABLE(8'hA5), .WRAP(1'b1)) u_one (
    .clk(clk), .rst(rst), .ctrl_valid(cv2), .ctrl_ready(rdy2), .restart(rs2),
    .outs(o2), .outs_valid(ov2), .outs_ready(or2), .outs_last(ol2), .idx(ix2));

  int n_pass = 0;
  int n_total = 0;
  int cur = 0;
  logic cur_cv, cur_rs, cur_ordy;
  int m_idx = 0;
  logic [8:0] sbq[$];  // {last, data}

  logic       a_valid, a_last, a_ready;
  logic [7:0] a_outs;
  logic [1:0] a_idx;

  typedef struct {
    logic       cv, rs, ordy;
    logic       e_valid;
    logic [7:0] e_outs;
    logic       e_last, e_ready;
    logic [1:0] e_idx;
  } vec_t;

  vec_t vecs[22];

  function automatic vec_t mk(input logic cv, input logic rs, input logic ordy,
                              input logic ev, input logic [7:0] eo, input logic el,
                              input logic er, input logic [1:0] ei);
    vec_t v;
    v.cv = cv; v.rs = rs; v.ordy = ordy;
    v.e_valid = ev; v.e_outs = eo; v.e_last = el; v.e_ready = er; v.e_idx = ei;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int m_depth();
    return (cur == 2) ? 1 : 3;
  endfunction

  function automatic logic [7:0] m_tab(input int i);
    if (cur == 2) return 8'hA5;
    case (i)
      0:       return 8'h11;
      1:       return 8'h22;
      default: return 8'h33;
    endcase
  endfunction

  task automatic sample();
    case (cur)
      0: begin a_valid = ov0; a_outs = o0; a_last = ol0; a_ready = rdy0; a_idx = ix0; end
      1: begin a_valid = ov1; a_outs = o1; a_last = ol1; a_ready = rdy1; a_idx = ix1; end
      default: begin a_valid = ov2; a_outs = o2; a_last = ol2; a_ready = rdy2; a_idx = {1'b0, ix2}; end
    endcase
  endtask

  // Drive inputs of the selected DUT (others idle), then move to the negedge.
  task automatic drive(input logic cv, input logic rs, input logic ordy);
    cv0 = 0; rs0 = 0; or0 = 1; cv1 = 0; rs1 = 0; or1 = 1; cv2 = 0; rs2 = 0; or2 = 1;
    case (cur)
      0: begin cv0 = cv; rs0 = rs; or0 = ordy; end
      1: begin cv1 = cv; rs1 = rs; or1 = ordy; end
      default: begin cv2 = cv; rs2 = rs; or2 = ordy; end
    endcase
    cur_cv = cv; cur_rs = rs; cur_ordy = ordy;
    @(negedge clk);
    sample();
  endtask

  // Scoreboard: compare head token, then apply this cycle's fires to the model.
  task automatic sb_check(input string tag);
    logic ev;
    logic [8:0] tok;
    ev = (sbq.size() != 0);
    chk({tag, " valid"}, 32'(a_valid), 32'(ev));
    if (ev) begin
      tok = sbq[0];
      chk({tag, " outs"}, 32'(a_outs), 32'(tok[7:0]));
      chk({tag, " last"}, 32'(a_last), 32'(tok[8]));
    end
    chk({tag, " ready"}, 32'(a_ready), 32'(!ev || cur_ordy));
    chk({tag, " idx"}, 32'(a_idx), 32'(m_idx));
    if (ev && cur_ordy) void'(sbq.pop_front());
    if (cur_cv && (!ev || cur_ordy)) begin
      sbq.push_back({(m_idx == m_depth() - 1), m_tab(m_idx)});
      if (m_idx == m_depth() - 1) m_idx = (cur == 1) ? m_idx : 0;
      else m_idx = m_idx + 1;
    end
    if (cur_rs) m_idx = 0;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input string tag, input logic cv, input logic rs, input logic ordy);
    drive(cv, rs, ordy);
    sb_check(tag);
    advance();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] seen[$];
    logic       seen_last[$];
    logic [7:0] sat_exp[5];

    sat_exp[0] = 8'h11; sat_exp[1] = 8'h22; sat_exp[2] = 8'h33;
    sat_exp[3] = 8'h33; sat_exp[4] = 8'h33;

    //          cv rs ordy  valid outs  last ready idx
    vecs[0]  = mk(1, 0, 1,  0, 8'h00, 0, 1, 0);
    vecs[1]  = mk(1, 0, 1,  1, 8'h11, 0, 1, 1);
    vecs[2]  = mk(1, 0, 1,  1, 8'h22, 0, 1, 2);
    vecs[3]  = mk(1, 0, 1,  1, 8'h33, 1, 1, 0);
    vecs[4]  = mk(1, 0, 1,  1, 8'h11, 0, 1, 1);
    vecs[5]  = mk(0, 1, 1,  1, 8'h22, 0, 1, 2);
    vecs[6]  = mk(1, 0, 0,  0, 8'h22, 0, 1, 0);
    vecs[7]  = mk(1, 0, 0,  1, 8'h11, 0, 0, 1);
    vecs[8]  = mk(1, 0, 0,  1, 8'h11, 0, 0, 1);
    vecs[9]  = mk(1, 0, 1,  1, 8'h11, 0, 1, 1);
    vecs[10] = mk(0, 0, 1,  1, 8'h22, 0, 1, 2);
    vecs[11] = mk(0, 0, 1,  0, 8'h22, 0, 1, 2);
    vecs[12] = mk(1, 0, 1,  0, 8'h22, 0, 1, 2);
    vecs[13] = mk(1, 0, 1,  1, 8'h33, 1, 1, 0);
    vecs[14] = mk(1, 1, 1,  1, 8'h11, 0, 1, 1);
    vecs[15] = mk(1, 0, 1,  1, 8'h22, 0, 1, 0);
    vecs[16] = mk(0, 1, 0,  1, 8'h11, 0, 0, 1);
    vecs[17] = mk(0, 0, 0,  1, 8'h11, 0, 0, 0);
    vecs[18] = mk(0, 0, 1,  1, 8'h11, 0, 1, 0);
    vecs[19] = mk(1, 0, 1,  0, 8'h11, 0, 1, 0);
    vecs[20] = mk(1, 0, 1,  1, 8'h11, 0, 1, 1);
    vecs[21] = mk(0, 0, 0,  1, 8'h22, 0, 0, 2);

    // Reset state of all three instances
    rst = 1'b0;
    cv0 = 0; rs0 = 0; or0 = 1; cv1 = 0; rs1 = 0; or1 = 1; cv2 = 0; rs2 = 0; or2 = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst wrap valid", 32'(ov0), 0); chk("rst wrap outs", 32'(o0), 0);
    chk("rst wrap last", 32'(ol0), 0);  chk("rst wrap idx", 32'(ix0), 0);
    chk("rst sat valid", 32'(ov1), 0);  chk("rst one valid", 32'(ov2), 0);
    chk("rst one idx", 32'(ix2), 0);
    rst = 1'b1;

    // Vector table on the wrapping instance: stream, backpressure, restart
    cur = 0; m_idx = 0; sbq.delete();
    for (int i = 0; i < 22; i++) begin
      drive(vecs[i].cv, vecs[i].rs, vecs[i].ordy);
      sb_check($sformatf("sb row%0d", i));
      chk($sformatf("vec%0d valid", i), 32'(a_valid), 32'(vecs[i].e_valid));
      chk($sformatf("vec%0d outs", i), 32'(a_outs), 32'(vecs[i].e_outs));
      chk($sformatf("vec%0d last", i), 32'(a_last), 32'(vecs[i].e_last));
      chk($sformatf("vec%0d ready", i), 32'(a_ready), 32'(vecs[i].e_ready));
      chk($sformatf("vec%0d idx", i), 32'(a_idx), 32'(vecs[i].e_idx));
      advance();
    end

    // Asynchronous reset while a token is held at idx=2
    #2;
    rst = 1'b0;
    #1;
    chk("async rst valid", 32'(ov0), 0);
    chk("async rst outs", 32'(o0), 0);
    chk("async rst last", 32'(ol0), 0);
    chk("async rst idx", 32'(ix0), 0);
    sbq.delete(); m_idx = 0;
    advance();
    rst = 1'b1;
    cyc("post-rst c0", 1, 0, 1);
    drive(0, 0, 1);
    chk("post-rst first outs", 32'(a_outs), 32'h11);
    sb_check("post-rst c1");
    advance();
    cyc("post-rst c2", 0, 0, 1);

    // Saturating instance: five fires
    cur = 1; m_idx = 0; sbq.delete();
    for (int i = 0; i < 7; i++) begin
      drive((i < 5) ? 1'b1 : 1'b0, 0, 1);
      if (a_valid) begin seen.push_back(a_outs); seen_last.push_back(a_last); end
      sb_check($sformatf("sat c%0d", i));
      advance();
    end
    chk("sat token count", 32'(seen.size()), 5);
    for (int i = 0; i < 5 && i < seen.size(); i++) begin
      chk($sformatf("sat tok%0d", i), 32'(seen[i]), 32'(sat_exp[i]));
      chk($sformatf("sat last%0d", i), 32'(seen_last[i]), (i >= 2) ? 1 : 0);
    end
    chk("sat idx held", 32'(ix1), 2);

    // Single-entry instance: three fires, with a stall in between
    cur = 2; m_idx = 0; sbq.delete();
    cyc("one c0", 1, 0, 1);
    cyc("one c1", 1, 0, 0);
    cyc("one c2", 1, 0, 1);
    cyc("one c3", 1, 0, 1);
    cyc("one c4", 0, 0, 1);
    cyc("one c5", 0, 0, 1);
    chk("one idx", 32'(ix2), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
